// File: rtl/ddr_ser_tx_pkg.sv
// Shared helpers for the DDR serial transmitter slice.
package ddr_ser_tx_pkg;

    // Pair-counter width; a single-pair word still needs one bit of counter.
    function automatic int cnt_width(input int npair);
        return (npair <= 1) ? 1 : $clog2(npair);
    endfunction

endpackage

// File: rtl/ddr_out_cell.sv
// DDR output cell: posedge A/B pair register, negedge B register and CLK-driven output mux.
module ddr_out_cell #(
    parameter logic INIT = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic pair_a,
    input  logic pair_b,
    output logic Q
);

    logic a_reg;
    logic b_reg;
    logic neg_reg;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            a_reg <= INIT;
            b_reg <= INIT;
        end else begin
            a_reg <= pair_a;
            b_reg <= pair_b;
        end
    end

    // B is re-timed to the falling edge so it is stable for the whole low phase.
    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            neg_reg <= INIT;
        end else begin
            neg_reg <= b_reg;
        end
    end

    assign Q = CLK ? a_reg : neg_reg;

endmodule

// File: rtl/ddr_ser_tx.sv
// DDR serial transmitter: valid/ready word intake, pair counter and shift register feeding ddr_out_cell.
module ddr_ser_tx
    import ddr_ser_tx_pkg::*;
#(
    parameter int   DWIDTH    = 8,
    parameter logic INIT      = 1'b0,
    parameter int   MSB_FIRST = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DWIDTH-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic              Q,
    output logic              Q_EN,
    output logic              TX_BUSY
);

    localparam int NPAIR = DWIDTH / 2;
    localparam int CW    = cnt_width(NPAIR);

    logic [CW-1:0]     cnt;
    logic [DWIDTH-1:0] shift_reg;
    logic [DWIDTH-1:0] ordered;
    logic              accept;
    logic              pair_a;
    logic              pair_b;

    // Reorder so the first bit to send always sits at the top of the word.
    always_comb begin
        ordered = '0;
        for (int i = 0; i < DWIDTH; i++) begin
            ordered[i] = (MSB_FIRST != 0) ? TX_DATA[i] : TX_DATA[DWIDTH-1-i];
        end
    end

    assign TX_READY = ~RESET & (cnt == '0);
    assign accept   = TX_VALID & TX_READY;
    assign TX_BUSY  = Q_EN | (cnt != '0);

    always_comb begin
        pair_a = INIT;
        pair_b = INIT;
        if (accept) begin
            pair_a = ordered[DWIDTH-1];
            pair_b = ordered[DWIDTH-2];
        end else if (cnt != '0) begin
            pair_a = shift_reg[DWIDTH-1];
            pair_b = shift_reg[DWIDTH-2];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt       <= '0;
            shift_reg <= '0;
            Q_EN      <= 1'b0;
        end else if (accept) begin
            shift_reg <= ordered << 2;
            cnt       <= CW'(NPAIR - 1);
            Q_EN      <= 1'b1;
        end else if (cnt != '0) begin
            shift_reg <= shift_reg << 2;
            cnt       <= cnt - 1'b1;
            Q_EN      <= 1'b1;
        end else begin
            Q_EN      <= 1'b0;
        end
    end

    ddr_out_cell #(
        .INIT(INIT)
    ) u_out (
        .CLK   (CLK),
        .RESET (RESET),
        .pair_a(pair_a),
        .pair_b(pair_b),
        .Q     (Q)
    );

endmodule

// File: tb/tb_ddr_ser_tx.sv
// Bench for ddr_ser_tx: four parameter variants checked against a bit-queue model every half cycle.
module tb_ddr_ser_tx;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    logic [7:0] data [4];
    logic       valid[4];
    logic       q_o [4];
    logic       en_o[4];
    logic       rdy_o[4];
    logic       busy_o[4];

    int   pw   [4] = '{8, 8, 8, 2};
    int   pmsb [4] = '{1, 0, 1, 1};
    logic pinit[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    // model state: upcoming bits in send order, currently shown pair, enable
    bit   mq[4][$];
    logic ea [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic eb [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic een[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int   acc_cnt[4] = '{0, 0, 0, 0};
    bit   cap[4][$];

    int checks   = 0;
    int failures = 0;

    ddr_ser_tx #(.DWIDTH(8), .INIT(1'b0), .MSB_FIRST(1)) dut0 (
        .CLK(CLK), .RESET(rst), .TX_DATA(data[0]), .TX_VALID(valid[0]),
        .TX_READY(rdy_o[0]), .Q(q_o[0]), .Q_EN(en_o[0]), .TX_BUSY(busy_o[0]));
    ddr_ser_tx #(.DWIDTH(8), .INIT(1'b0), .MSB_FIRST(0)) dut1 (
        .CLK(CLK), .RESET(rst), .TX_DATA(data[1]), .TX_VALID(valid[1]),
        .TX_READY(rdy_o[1]), .Q(q_o[1]), .Q_EN(en_o[1]), .TX_BUSY(busy_o[1]));
    ddr_ser_tx #(.DWIDTH(8), .INIT(1'b1), .MSB_FIRST(1)) dut2 (
        .CLK(CLK), .RESET(rst), .TX_DATA(data[2]), .TX_VALID(valid[2]),
        .TX_READY(rdy_o[2]), .Q(q_o[2]), .Q_EN(en_o[2]), .TX_BUSY(busy_o[2]));
    ddr_ser_tx #(.DWIDTH(2), .INIT(1'b0), .MSB_FIRST(1)) dut3 (
        .CLK(CLK), .RESET(rst), .TX_DATA(data[3][1:0]), .TX_VALID(valid[3]),
        .TX_READY(rdy_o[3]), .Q(q_o[3]), .Q_EN(en_o[3]), .TX_BUSY(busy_o[3]));

    task automatic chk(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%b expected=%b t=%0t", name, i, act, exp, $time);
        end
    endtask

    // Model: a word enters the queue when the queue is empty; each posedge shows the next pair.
    initial forever begin
        @(posedge CLK or posedge rst);
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                mq[i].delete();
                ea[i]  = pinit[i];
                eb[i]  = pinit[i];
                een[i] = 1'b0;
            end else begin
                if (valid[i] && mq[i].size() == 0) begin
                    for (int j = 0; j < pw[i]; j++)
                        mq[i].push_back(pmsb[i] != 0 ? data[i][pw[i]-1-j] : data[i][j]);
                    acc_cnt[i]++;
                end
                if (mq[i].size() > 0) begin
                    ea[i]  = mq[i].pop_front();
                    eb[i]  = mq[i].pop_front();
                    een[i] = 1'b1;
                end else begin
                    ea[i]  = pinit[i];
                    eb[i]  = pinit[i];
                    een[i] = 1'b0;
                end
            end
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("q_high", i, q_o[i], ea[i]);
            chk("q_en_high", i, en_o[i], een[i]);
            chk("tx_ready", i, rdy_o[i], !rst && mq[i].size() == 0);
            chk("tx_busy", i, busy_o[i], een[i] || mq[i].size() != 0);
            if (en_o[i]) cap[i].push_back(q_o[i]);
        end
    end

    initial forever begin
        @(negedge CLK);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("q_low", i, q_o[i], eb[i]);
            chk("q_en_low", i, en_o[i], een[i]);
            if (en_o[i]) cap[i].push_back(q_o[i]);
        end
    end

    task automatic wait_acc(input int i, input int start);
        int n = 0;
        while (acc_cnt[i] == start && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (acc_cnt[i] == start) begin
            failures++;
            $display("FAIL accept_timeout dut%0d actual=no_accept expected=accept", i);
        end
    endtask

    task automatic send(input int i, input logic [7:0] d);
        int start;
        start    = acc_cnt[i];
        data[i]  = d;
        valid[i] = 1'b1;
        wait_acc(i, start);
        #2;
        valid[i] = 1'b0;
    endtask

    task automatic chk_cap(input string name, input int i, input logic [15:0] exp, input int n);
        string s = "";
        bit ok = (cap[i].size() == n);
        foreach (cap[i][j]) s = {s, cap[i][j] ? "1" : "0"};
        if (ok) for (int j = 0; j < n; j++) if (cap[i][j] != exp[n-1-j]) ok = 0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s dut%0d actual=%s expected=%b (%0d bits)", name, i, s, exp, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        for (int i = 0; i < 4; i++) begin
            data[i]  = 8'h00;
            valid[i] = 1'b0;
        end
        repeat (3) @(negedge CLK);
        #2;
        chk("reset_q_init1", 2, q_o[2], 1'b1);
        chk("reset_ready", 0, rdy_o[0], 1'b0);
        chk("reset_q_en", 0, en_o[0], 1'b0);
        rst = 1'b0;
        @(negedge CLK);
        #2;
        chk("ready_after_reset", 0, rdy_o[0], 1'b1);
        chk("ready_after_reset", 3, rdy_o[3], 1'b1);

        cap[0].delete();
        send(0, 8'hA5);
        repeat (6) @(negedge CLK);
        chk_cap("basic_a5", 0, 16'h00A5, 8);
        chk("idle_q", 0, q_o[0], 1'b0);
        chk("idle_q_en", 0, en_o[0], 1'b0);

        cap[0].delete();
        send(0, 8'hA5);
        send(0, 8'h3C);
        repeat (6) @(negedge CLK);
        chk_cap("back_to_back", 0, 16'hA53C, 16);

        cap[0].delete();
        start = acc_cnt[0];
        data[0]  = 8'hA5;
        valid[0] = 1'b1;
        wait_acc(0, start);
        repeat (3) begin
            #2;
            data[0] = 8'($urandom);
            @(negedge CLK);
        end
        #2;
        valid[0] = 1'b0;
        repeat (6) @(negedge CLK);
        checks++;
        if (acc_cnt[0] - start != 1) begin
            failures++;
            $display("FAIL stall_accepts dut0 actual=%0d expected=1", acc_cnt[0] - start);
        end
        chk_cap("stall_word", 0, 16'h00A5, 8);

        cap[1].delete();
        send(1, 8'h01);
        repeat (6) @(negedge CLK);
        chk_cap("lsb_first", 1, 16'h0080, 8);

        cap[2].delete();
        send(2, 8'h3C);
        repeat (6) @(negedge CLK);
        chk_cap("init1_word", 2, 16'h003C, 8);
        #1;
        chk("init1_idle_low", 2, q_o[2], 1'b1);
        @(posedge CLK);
        #2;
        chk("init1_idle_high", 2, q_o[2], 1'b1);

        cap[3].delete();
        @(negedge CLK);
        #2;
        send(3, 8'h02);
        send(3, 8'h01);
        repeat (4) @(negedge CLK);
        chk_cap("dw2_b2b", 3, 16'h0009, 4);

        send(0, 8'hFF);
        @(posedge CLK);
        @(negedge CLK);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_q", 0, q_o[0], 1'b0);
        chk("rst_mid_q_en", 0, en_o[0], 1'b0);
        chk("rst_mid_ready", 0, rdy_o[0], 1'b0);
        chk("rst_mid_busy", 0, busy_o[0], 1'b0);
        repeat (2) @(negedge CLK);
        #3;
        rst = 1'b0;
        cap[0].delete();
        send(0, 8'h81);
        repeat (6) @(negedge CLK);
        chk_cap("after_reset_81", 0, 16'h0081, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
